// File: rtl/dmem_port_arbiter_pkg.sv
// processor_defines: shared memory-mode, arbiter-state and round-robin encodings
package processor_defines;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    localparam logic STORE_FIRST = 1'b0;
    localparam logic LOAD_FIRST  = 1'b1;

    localparam int CNT_W = 3;

    typedef enum logic {
        IDLE,
        RD_WAIT
    } arb_state_t;

endpackage

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, bit 0 = store, bit 1 = load
module rr_arb2
    import processor_defines::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       contested
);

    logic load_wins;

    // On contention the pointer decides; otherwise the lone requester wins
    always_comb begin
        contested = en & req[0] & req[1];
        load_wins = contested ? (ptr == LOAD_FIRST) : req[1];
        gnt[1]    = en & req[1] & load_wins;
        gnt[0]    = en & req[0] & ~gnt[1];
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data-memory port between load and store units
module dmem_port_arbiter
    import processor_defines::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [31:0]       ld_rdata,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_wdata,
    input  logic [3:0]        st_wstrb,
    output logic              st_gnt,
    output logic              mem_en,
    output logic              mem_rw_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,
    output logic              stall_pc
);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             rr_ptr;
    logic [1:0]       gnt;
    logic             contested;
    logic             rd_wait;

    // Grants only happen in IDLE and are suppressed while reset is held
    rr_arb2 u_arb (
        .req       ({ld_req, st_req}),
        .ptr       (rr_ptr),
        .en        ((state == IDLE) & i_rst),
        .gnt       (gnt),
        .contested (contested)
    );

    // Memory port and handshake outputs decoded from state and the current grant
    always_comb begin
        rd_wait     = (state == RD_WAIT);
        st_gnt      = gnt[0];
        ld_gnt      = gnt[1];
        mem_en      = st_gnt | ld_gnt;
        mem_rw_mode = st_gnt ? MEM_WRITE : MEM_READ;
        mem_addr    = st_gnt ? st_addr : (ld_gnt ? ld_addr : '0);
        mem_wdata   = st_gnt ? st_wdata : '0;
        mem_wstrb   = st_gnt ? st_wstrb : '0;
        ld_rvalid   = rd_wait & (cnt == '0);
        ld_rdata    = ld_rvalid ? mem_rdata : '0;
        stall_pc    = i_rst & (ld_gnt | (ld_req & ~ld_gnt) | (st_req & ~st_gnt) | rd_wait);
    end

    // Read-latency tracking and round-robin pointer update after contested grants
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rr_ptr <= STORE_FIRST;
        end else if (state == IDLE) begin
            if (contested)
                rr_ptr <= ~rr_ptr;
            if (ld_gnt) begin
                state <= RD_WAIT;
                cnt   <= CNT_W'(RD_LATENCY - 1);
            end
        end else if (cnt == '0) begin
            state <= IDLE;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule
